// File: rtl/pnser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pnser_pkg
// Purpose  : Shared constants, FSM states and length decode for the serializer.
// Revision : 1.0
// ============================================================================
package pnser_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A zero length field stands for a full-width word.
    function automatic int unsigned len_decode(input int unsigned len, input int unsigned dw);
        return (len == 0) ? dw : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pnser_shreg.sv
`default_nettype none
// ============================================================================
// Module   : pnser_shreg
// Purpose  : Active shift stage: word register, bit counter, registered bit/last.
// Revision : 1.0
// ============================================================================
module pnser_shreg
    import pnser_pkg::*;
#(
    parameter int DW = 32,
    parameter int LW = $clog2(DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [DW-1:0] dat_i,
    input  logic [LW:0]   len_i,
    input  logic          mode_i,
    output logic          dat_o,
    output logic          vld_o,
    output logic          last_o
);

    logic [DW-1:0] r_data;
    logic          r_mode;
    logic [LW:0]   r_cnt;
    logic          r_bit;
    logic          r_vld;
    logic          r_last;

    // r_data holds only the bits not yet presented, so r_bit is always a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
            r_mode <= MODE_MSB;
            r_cnt  <= '0;
            r_bit  <= 1'b0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (load_i) begin
            r_mode <= mode_i;
            r_cnt  <= len_i;
            r_vld  <= 1'b1;
            r_last <= (len_i == (LW+1)'(1));
            if (mode_i == MODE_LSB) begin
                r_bit  <= dat_i[0];
                r_data <= dat_i >> 1;
            end else begin
                r_bit  <= dat_i[DW-1];
                r_data <= dat_i << 1;
            end
        end else if (shift_i && r_vld) begin
            if (r_cnt == (LW+1)'(1)) begin
                r_cnt  <= '0;
                r_bit  <= 1'b0;
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - (LW+1)'(1);
                r_last <= (r_cnt == (LW+1)'(2));
                if (r_mode == MODE_LSB) begin
                    r_bit  <= r_data[0];
                    r_data <= r_data >> 1;
                end else begin
                    r_bit  <= r_data[DW-1];
                    r_data <= r_data << 1;
                end
            end
        end
    end

    assign dat_o  = r_bit;
    assign vld_o  = r_vld;
    assign last_o = r_last;

endmodule
`default_nettype wire

// File: rtl/pnser_stream.sv
`default_nettype none
// ============================================================================
// Module   : pnser_stream
// Purpose  : Handshaked parallel-to-serial stream with one-word holding register.
// Revision : 1.0
// ============================================================================
module pnser_stream
    import pnser_pkg::*;
#(
    parameter int DW = 32,
    parameter int LW = $clog2(DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] dat_i,
    input  logic [LW-1:0] len_i,
    input  logic          mode_i,
    input  logic          vld_i,
    output logic          rdy_o,
    input  logic          en_i,
    output logic          dat_o,
    output logic          dat_vld_o,
    output logic          last_o,
    output logic          ack_o,
    output logic          busy_o
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_hold_full;
    logic [DW-1:0] r_hold_dat;
    logic [LW:0]   r_hold_len;
    logic          r_hold_mode;
    logic          r_ack;

    logic          w_vld;
    logic          w_last;
    logic          w_accept;
    logic          w_final;
    logic          w_direct;
    logic          w_to_hold;
    logic          w_from_hold;
    logic          w_load;
    logic [LW:0]   w_in_len;
    logic [DW-1:0] w_load_dat;
    logic [LW:0]   w_load_len;
    logic          w_load_mode;

    assign w_in_len    = (LW+1)'(len_decode(32'(len_i), DW));
    assign w_accept    = vld_i & ~r_hold_full;
    assign w_final     = en_i & w_last;
    // A word bypasses the hold whenever the shifter is free by the end of this edge.
    assign w_direct    = w_accept & ((r_state == IDLE) | w_final);
    assign w_to_hold   = w_accept & ~w_direct;
    assign w_from_hold = w_final & r_hold_full;
    assign w_load      = w_direct | w_from_hold;
    assign w_load_dat  = w_from_hold ? r_hold_dat  : dat_i;
    assign w_load_len  = w_from_hold ? r_hold_len  : w_in_len;
    assign w_load_mode = w_from_hold ? r_hold_mode : mode_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_final && !w_from_hold && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_dat  <= '0;
            r_hold_len  <= '0;
            r_hold_mode <= MODE_MSB;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_final;
            if (w_to_hold) begin
                r_hold_full <= 1'b1;
                r_hold_dat  <= dat_i;
                r_hold_len  <= w_in_len;
                r_hold_mode <= mode_i;
            end else if (w_from_hold) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    pnser_shreg #(
        .DW (DW),
        .LW (LW)
    ) u_shreg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (w_load),
        .shift_i (en_i),
        .dat_i   (w_load_dat),
        .len_i   (w_load_len),
        .mode_i  (w_load_mode),
        .dat_o   (dat_o),
        .vld_o   (w_vld),
        .last_o  (w_last)
    );

    assign dat_vld_o = w_vld;
    assign last_o    = w_last;
    assign ack_o     = r_ack;
    assign rdy_o     = ~r_hold_full;
    assign busy_o    = (r_state == SHIFT) | r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_pnser_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_pnser_stream
// Purpose  : Self-checking bench: directed vector table, corner sequences, random.
// Revision : 1.0
// ============================================================================
module tb_pnser_stream;

    localparam int DW = 32;
    localparam int LW = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] dat_i;
    logic [LW-1:0] len_i;
    logic          mode_i;
    logic          vld_i;
    logic          en_i;
    logic          rdy_o;
    logic          dat_o;
    logic          dat_vld_o;
    logic          last_o;
    logic          ack_o;
    logic          busy_o;

    always #5 clk = ~clk;

    pnser_stream #(
        .DW (DW),
        .LW (LW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .dat_i     (dat_i),
        .len_i     (len_i),
        .mode_i    (mode_i),
        .vld_i     (vld_i),
        .rdy_o     (rdy_o),
        .en_i      (en_i),
        .dat_o     (dat_o),
        .dat_vld_o (dat_vld_o),
        .last_o    (last_o),
        .ack_o     (ack_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        logic [DW-1:0] dat;
        logic [LW-1:0] len;
        logic          mode;
        int            period;
        logic [31:0]   exp_bits;
        int            exp_n;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;

    // Reference model: pending serial bits in send order, and words outstanding.
    bit exp_bits[$];
    bit exp_last[$];
    int words = 0;
    bit exp_ack = 1'b0;
    bit last_accept = 1'b0;
    int cyc = 0;
    int ack_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic m);
        int n;
        n = (l == 0) ? DW : int'(l);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(m ? d[i] : d[DW-1-i]);
            exp_last.push_back(i == n - 1);
        end
        words++;
    endtask

    task automatic compare_outputs();
        check("dat_vld", dat_vld_o, (words > 0));
        check("rdy", rdy_o, (words < 2));
        check("busy", busy_o, (words > 0));
        check("ack", ack_o, exp_ack);
        check("dat", dat_o, (words > 0) ? exp_bits[0] : 1'b0);
        check("last", last_o, (words > 0) ? exp_last[0] : 1'b0);
    endtask

    // One clock: inputs already driven; advance model and compare after the edge.
    task automatic cycle();
        bit            acc;
        bit            con;
        bit            fin;
        bit            prev_hold;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        logic          m;
        acc       = vld_i && (words < 2);
        con       = en_i && (words > 0);
        fin       = con && exp_last[0];
        prev_hold = (words == 2);
        d = dat_i;
        l = len_i;
        m = mode_i;
        @(posedge clk);
        #1;
        cyc++;
        if (con) begin
            void'(exp_bits.pop_front());
            void'(exp_last.pop_front());
            if (fin) words--;
        end
        if (acc) push_word(d, l, m);
        exp_ack     = fin;
        last_accept = acc;
        if (ack_o) ack_cyc.push_back(cyc);
        compare_outputs();
        if (prev_hold) check("hold_no_bubble", dat_vld_o, 1'b1);
    endtask

    task automatic run_word(input vec_t v, input string name);
        logic [31:0] cap;
        logic [31:0] lcap;
        int          n;
        bit          accepted;
        bit          done;
        cap = '0; lcap = '0; n = 0; accepted = 1'b0; done = 1'b0;
        dat_i  = v.dat;
        len_i  = v.len;
        mode_i = v.mode;
        vld_i  = 1'b1;
        ack_cyc.delete();
        for (int k = 0; k < 400 && !done; k++) begin
            en_i = ((k % v.period) == 0);
            if (en_i && dat_vld_o) begin
                cap  = {cap[30:0], dat_o};
                lcap = {lcap[30:0], last_o};
                n++;
            end
            cycle();
            if (last_accept) begin
                accepted = 1'b1;
                vld_i    = 1'b0;
            end
            if (accepted && !dat_vld_o) done = 1'b1;
        end
        en_i = 1'b0;
        cycle();
        cycle();
        check({name, "_done"}, done, 1'b1);
        check({name, "_bits"}, cap, v.exp_bits);
        check({name, "_nbits"}, n, v.exp_n);
        check({name, "_last_pos"}, lcap, 32'h1);
        check({name, "_acks"}, ack_cyc.size(), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        bit vdone;

        vecs[0] = '{32'hAB000000, 5'd8,  1'b0, 1, 32'h000000AB, 8};
        vecs[1] = '{32'h000000D5, 5'd8,  1'b1, 1, 32'h000000AB, 8};
        vecs[2] = '{32'h80000001, 5'd0,  1'b0, 1, 32'h80000001, 32};
        vecs[3] = '{32'hF0000000, 5'd4,  1'b0, 4, 32'h0000000F, 4};
        vecs[4] = '{32'h00000001, 5'd1,  1'b1, 1, 32'h00000001, 1};
        vecs[5] = '{32'h9AB00000, 5'd12, 1'b0, 2, 32'h000009AB, 12};

        rst_ni = 1'b1; dat_i = '0; len_i = '0; mode_i = 1'b0; vld_i = 1'b0; en_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        compare_outputs();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_word(vecs[i], $sformatf("vec%0d", i));

        // Second word offered while the first is shifting.
        ack_cyc.delete();
        dat_i = 32'hAB000000; len_i = 5'd8; mode_i = 1'b0; vld_i = 1'b1; en_i = 1'b1;
        cycle();
        dat_i = 32'h9AB00000; len_i = 5'd12;
        nvalid = 0; vdone = 1'b0;
        for (int k = 0; k < 60 && !vdone; k++) begin
            if (dat_vld_o) begin
                nvalid++;
                cycle();
                if (last_accept) vld_i = 1'b0;
            end else begin
                vdone = 1'b1;
            end
        end
        check("b2b_valid_run", nvalid, 20);
        check("b2b_ack_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) check("b2b_ack_gap", ack_cyc[1] - ack_cyc[0], 12);
        en_i = 1'b0;
        cycle();

        // Reset after three bits of a 12-bit word.
        dat_i = 32'h9AB00000; len_i = 5'd12; mode_i = 1'b0; vld_i = 1'b1; en_i = 1'b1;
        cycle();
        vld_i = 1'b0;
        repeat (3) cycle();
        ack_cyc.delete();
        #2 rst_ni = 1'b0;
        #1;
        exp_bits.delete(); exp_last.delete(); words = 0; exp_ack = 1'b0;
        compare_outputs();
        en_i = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        en_i = 1'b1;
        repeat (3) cycle();
        check("rst_no_ack", ack_cyc.size(), 0);
        run_word(vecs[5], "post_rst");

        // Random traffic including back-to-back short words.
        vld_i = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (!vld_i && ($urandom % 2 == 0)) begin
                dat_i  = $urandom;
                len_i  = ($urandom % 4 == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(1, 5));
                mode_i = 1'($urandom % 2);
                vld_i  = 1'b1;
            end
            en_i = (($urandom % 4) != 0);
            cycle();
            if (last_accept) vld_i = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
